nios_pio_in_edge: RTL and testbench

- Parametrised Avalon-MM input PIO slave for the Nios system.
- Samples WIDTH asynchronous input pins through a synchroniser and exposes live data at offset 0.
- Adds per-bit edge capture, an interrupt mask and a level-sensitive irq to the CPU.
- Replaces single-bit polled inputs such as DIP switches and push-buttons with one interrupt-capable block.

---
 rtl/nios_pio_pkg.sv | 22 ++
 rtl/nios_pio_debounce.sv | 55 +++++
 rtl/nios_pio_in_edge.sv | 149 ++++++++++++++
 tb/tb_nios_pio_in_edge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package  : nios_pio_pkg                                                   |
// | Purpose  : Shared constants for the Nios input PIO with edge capture:     |
// |            Avalon word offsets and EDGE_TYPE encodings.                   |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
package nios_pio_pkg;

  // Avalon word offsets (address is a 2-bit word index)
  localparam logic [1:0] PIO_DATA_ADDR     = 2'd0;
  localparam logic [1:0] PIO_RSVD_ADDR     = 2'd1;
  localparam logic [1:0] PIO_IRQ_MASK_ADDR = 2'd2;
  localparam logic [1:0] PIO_EDGE_CAP_ADDR = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : nios_pio_pkg
`default_nettype wire

// File: rtl/nios_pio_debounce.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : nios_pio_debounce                                              |
// | Purpose  : Single-bit debouncer. The stable output db_o only follows the  |
// |            already-synchronised input once that input has held a new     |
// |            value for DEBOUNCE_CYCLES consecutive clocks.                  |
// | Ports    : clk      in  system clock                                      |
// |            reset_n  in  asynchronous reset, active-low                    |
// |            sync_i   in  synchronised input bit                            |
// |            db_o     out debounced bit (resets to 0)                       |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module nios_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic db_o
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        db_q,  db_d;

  // For a single bit, "input differs from the stable value" is the only way
  // the input can be holding a new value. Any return to the stable value
  // therefore restarts the count from zero.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_i != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_i;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule : nios_pio_debounce
`default_nettype wire

// File: rtl/nios_pio_in_edge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : nios_pio_in_edge                                               |
// | Purpose  : Avalon-MM input PIO slave with per-bit edge capture, an        |
// |            interrupt mask and a level-sensitive irq.                      |
// |            Map: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW),                 |
// |                 3 EDGE_CAPTURE (read, write-1-to-clear).                  |
// | Ports    : clk, reset_n (async, active-low)                               |
// |            chipselect, address[1:0], write_n, writedata[31:0]  Avalon     |
// |            in_port[WIDTH-1:0]  asynchronous input pins                    |
// |            readdata[31:0]      registered read data, 1-cycle latency      |
// |            irq                 level interrupt                            |
// | Options  : define NIOS_PIO_DEBOUNCE_EN to insert a per-bit debouncer of   |
// |            DEBOUNCE_CYCLES after the synchroniser.                        |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Arm counter saturates at SYNC_STAGES+1: by then prev_q holds a real
  // synchronised sample, so pins high out of reset do not look like edges.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  pin_val;   // value used for DATA and edges
  logic [WIDTH-1:0]                  prev_q;
  logic [2:0]                        arm_q, arm_d;
  logic                              armed;
  logic [WIDTH-1:0]                  edges;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q,  cap_d;
  logic [31:0]                       readdata_q, readdata_d;
  logic                              wr_en;
  logic                              unused_wdata;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // ------------------------------------------------------------ debounce
`ifdef NIOS_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_i  (sync_q[i]),
      .db_o    (pin_val[i])
    );
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign pin_val         = sync_q;
`endif

  // ------------------------------------------------------- edge detect
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edges = pin_val & ~prev_q;
      EDGE_FALL: edges = ~pin_val & prev_q;
      default:   edges = pin_val ^ prev_q;
    endcase
  end

  assign armed = (arm_q == ARM_MAX);
  assign arm_d = armed ? arm_q : arm_q + 3'd1;

  // -------------------------------------------------------- registers
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == PIO_IRQ_MASK_ADDR)) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  // Clear is applied first and new edges OR'd in afterwards, so an edge
  // landing in the same cycle as its clear is kept.
  always_comb begin
    cap_d = cap_q;
    if (wr_en && (address == PIO_EDGE_CAP_ADDR)) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    if (armed) begin
      cap_d = cap_d | edges;
    end
  end

  // Read data is registered every cycle from the presented address.
  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_DATA_ADDR:     readdata_d[WIDTH-1:0] = pin_val;
      PIO_IRQ_MASK_ADDR: readdata_d[WIDTH-1:0] = mask_q;
      PIO_EDGE_CAP_ADDR: readdata_d[WIDTH-1:0] = cap_q;
      default:           readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      arm_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= pin_val;
      arm_q      <= arm_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Flop outputs only: no combinational path from in_port to irq.
  assign irq      = |(cap_q & mask_q);

endmodule : nios_pio_in_edge
`default_nettype wire

// File: tb/tb_nios_pio_in_edge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_nios_pio_in_edge                                            |
// | Purpose  : Self-checking bench for nios_pio_in_edge. Two instances share  |
// |            the bus and pins: one capturing rising edges, one any edge.    |
// |            With NIOS_PIO_DEBOUNCE_EN defined the debounce flow runs.      |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_nios_pio_in_edge;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [7:0]  in_port    = '0;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [31:0] e0;
    logic [31:0] e2;
  } rd_exp_t;
  rd_exp_t sbq[$];

  typedef struct {
    logic [7:0] pin;
    logic [7:0] cap0;
    logic [7:0] cap2;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  nios_pio_in_edge #(
    .WIDTH (8), .SYNC_STAGES (2), .EDGE_TYPE (0), .DEBOUNCE_CYCLES (16)
  ) dut0 (
    .clk (clk), .reset_n (reset_n), .chipselect (chipselect), .address (address),
    .write_n (write_n), .writedata (writedata), .in_port (in_port),
    .readdata (rd0), .irq (irq0)
  );

  nios_pio_in_edge #(
    .WIDTH (8), .SYNC_STAGES (2), .EDGE_TYPE (2), .DEBOUNCE_CYCLES (16)
  ) dut2 (
    .clk (clk), .reset_n (reset_n), .chipselect (chipselect), .address (address),
    .write_n (write_n), .writedata (writedata), .in_port (in_port),
    .readdata (rd2), .irq (irq2)
  );

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_irq(string nm, logic e0, logic e2);
    chk({nm, "/irq_rise"}, 32'(irq0), 32'(e0));
    chk({nm, "/irq_any"},  32'(irq2), 32'(e2));
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Expected value queued when the address is presented, compared when the
  // registered readdata appears one clock later.
  task automatic rd(string nm, logic [1:0] a, logic [31:0] e0, logic [31:0] e2);
    rd_exp_t e;
    e.nm = nm;
    e.e0 = e0;
    e.e2 = e2;
    address = a;
    sbq.push_back(e);
    tick();
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.nm, "/rise"}, rd0, e.e0);
      chk({e.nm, "/any"},  rd2, e.e2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pin: 8'h0A, cap0: 8'h0A, cap2: 8'h0F};
    tbl[1] = '{pin: 8'h0A, cap0: 8'h00, cap2: 8'h00};
    tbl[2] = '{pin: 8'hFF, cap0: 8'hF5, cap2: 8'hF5};
    tbl[3] = '{pin: 8'h00, cap0: 8'h00, cap2: 8'hFF};
    tbl[4] = '{pin: 8'h81, cap0: 8'h81, cap2: 8'h81};
    tbl[5] = '{pin: 8'h18, cap0: 8'h18, cap2: 8'h99};

`ifndef NIOS_PIO_DEBOUNCE_EN
    // ---- reset with pins high
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick(3);
    chk("rst/readdata_rise", rd0, 32'h0);
    chk("rst/readdata_any",  rd2, 32'h0);
    chk_irq("rst", 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_irq("post_rst", 1'b0, 1'b0);
    end
    rd("post_rst/data", 2'd0, 32'hFF, 32'hFF);
    rd("post_rst/cap",  2'd3, 32'h0,  32'h0);

    // ---- rising-edge latency with mask 0x05
    wr(2'd2, 32'h5);
    in_port = 8'h00;
    tick(5);
    rd("fall/cap", 2'd3, 32'h0, 32'hFF);
    wr(2'd3, 32'hFF);
    rd("fall/cleared", 2'd3, 32'h0, 32'h0);
    in_port = 8'h05;
    address = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_irq($sformatf("lat%0d", k), k == 3, k == 3);
    end
    chk("lat3/readdata_pre", rd0, 32'h0);
    rd("lat/cap", 2'd3, 32'h5, 32'h5);

    // ---- write-1-to-clear
    wr(2'd3, 32'h1);
    chk_irq("clr1", 1'b1, 1'b1);
    rd("clr1/cap", 2'd3, 32'h4, 32'h4);
    wr(2'd3, 32'h4);
    chk_irq("clr4", 1'b0, 1'b0);
    rd("clr4/cap", 2'd3, 32'h0, 32'h0);

    // ---- clear and new edge on bit 1 in the same cycle
    in_port = 8'h07;
    tick();
    in_port = 8'h05;
    tick();
    wr(2'd3, 32'h2);
    tick(3);
    rd("simul/cap", 2'd3, 32'h2, 32'h2);
    chk_irq("simul", 1'b0, 1'b0);
    wr(2'd3, 32'hFF);

    // ---- edge table
    for (int i = 0; i < 6; i++) begin
      in_port = tbl[i].pin;
      tick(4);
      rd($sformatf("vec%0d/data", i), 2'd0, 32'(tbl[i].pin),  32'(tbl[i].pin));
      rd($sformatf("vec%0d/cap", i),  2'd3, 32'(tbl[i].cap0), 32'(tbl[i].cap2));
      wr(2'd3, 32'hFF);
    end

    // ---- bit 7 high then low with mask 0, then unmask
    wr(2'd2, 32'h0);
    in_port = 8'h98;
    tick(4);
    rd("b7rise/cap", 2'd3, 32'h80, 32'h80);
    chk_irq("b7rise", 1'b0, 1'b0);
    wr(2'd3, 32'hFF);
    in_port = 8'h18;
    tick(4);
    rd("b7fall/cap", 2'd3, 32'h0, 32'h80);
    chk_irq("b7fall", 1'b0, 1'b0);
    wr(2'd2, 32'h80);
    chk_irq("b7mask", 1'b0, 1'b1);
    rd("b7mask/mask", 2'd2, 32'h80, 32'h80);

    // ---- reset mid-operation
    reset_n = 1'b0;
    #1;
    chk_irq("midrst", 1'b0, 1'b0);
    chk("midrst/readdata_any", rd2, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    rd("midrst/mask", 2'd2, 32'h0, 32'h0);
    rd("midrst/cap",  2'd3, 32'h0, 32'h0);
    rd("midrst/data", 2'd0, 32'h18, 32'h18);
    chk_irq("midrst_after", 1'b0, 1'b0);
`else
    // ---- debounce: bouncing bit 0, then held high
    in_port = 8'h00;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    wr(2'd2, 32'h1);
    for (int b = 0; b < 2; b++) begin
      in_port = 8'h01;
      tick(3);
      in_port = 8'h00;
      tick(3);
    end
    rd("bounce/cap", 2'd3, 32'h0, 32'h0);
    in_port = 8'h01;
    address = 2'd0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) chk("db18/data", rd0, 32'h0);
      if (k == 19) chk("db19/data", rd0, 32'h1);
    end
    tick(3);
    rd("db/cap", 2'd3, 32'h1, 32'h1);
    chk_irq("db", 1'b1, 1'b1);
    wr(2'd3, 32'hFF);
    tick(20);
    rd("db/cap_once", 2'd3, 32'h0, 32'h0);
    chk_irq("db_once", 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nios_pio_in_edge
`default_nettype wire
